// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour codes and decoder state type.
// The timing constants are the same ones the generator uses.
package vga_pkg;

  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam int unsigned VGA_ERR_W     = 8;

  localparam int unsigned VGA_H_TOTAL  = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int unsigned VGA_HS_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int unsigned VGA_VS_START = VGA_V_DISPLAY + VGA_V_FRONT;

  localparam logic [2:0] CODE_BG      = 3'b000;
  localparam logic [2:0] CODE_BLUE    = 3'b001;
  localparam logic [2:0] CODE_GREEN   = 3'b010;
  localparam logic [2:0] CODE_YELLOW  = 3'b011;
  localparam logic [2:0] CODE_RED     = 3'b100;
  localparam logic [2:0] CODE_UNKNOWN = 3'b111;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } dec_state_t;

endpackage

// File: rtl/vga_color_classify.sv
// Combinational RGB -> 3-bit object code; a channel counts as ON at >= 128.
module vga_color_classify
  import vga_pkg::*;
(
  input  logic [7:0] i_Red,
  input  logic [7:0] i_Green,
  input  logic [7:0] i_Blue,
  output logic [2:0] o_Code
);

  logic [2:0] w_On;

  assign w_On = {i_Red >= 8'd128, i_Green >= 8'd128, i_Blue >= 8'd128};

  always_comb begin
    o_Code = CODE_UNKNOWN;
    case (w_On)
      3'b000:  o_Code = CODE_BG;
      3'b010:  o_Code = CODE_GREEN;
      3'b001:  o_Code = CODE_BLUE;
      3'b110:  o_Code = CODE_YELLOW;
      3'b100:  o_Code = CODE_RED;
      default: o_Code = CODE_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Locks onto a VGA sync/blank stream, rebuilds pixel coordinates and decodes
// active pixels back to object codes; flags timing violations while locked.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter int unsigned ERR_W     = VGA_ERR_W
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Pix_En,
  input  logic             i_hSync,
  input  logic             i_vSync,
  input  logic             i_Blank,
  input  logic [7:0]       i_Red,
  input  logic [7:0]       i_Green,
  input  logic [7:0]       i_Blue,
  output logic [9:0]       o_Pixel_X,
  output logic [9:0]       o_Pixel_Y,
  output logic             o_Pixel_Valid,
  output logic [2:0]       o_Pixel_Code,
  output logic             o_Frame_Start,
  output logic             o_Locked,
  output logic             o_Error,
  output logic [ERR_W-1:0] o_Err_Count
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;

  localparam logic [9:0] C_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_V_TOTAL  = 10'(V_TOTAL);
  localparam logic [9:0] C_HS_START = 10'(HS_START);
  localparam logic [9:0] C_VS_START = 10'(VS_START);
  localparam logic [9:0] C_H_DISP   = 10'(H_DISPLAY);
  localparam logic [9:0] C_V_DISP   = 10'(V_DISPLAY);

  dec_state_t       r_State, w_Next_State;
  logic [9:0]       r_X, r_Y, r_Line_Cnt;
  logic             r_HSync_Prev, r_VSync_Prev;
  logic             r_Locked, r_Error, r_Frame_Start, r_Valid;
  logic [2:0]       r_Code;
  logic [ERR_W-1:0] r_Err_Count;

  logic             w_HS_Fall, w_VS_Fall, w_X_Wrap;
  logic [9:0]       w_Pred_X, w_Pred_Y, w_X_New, w_Y_New;
  logic [9:0]       w_Line_Inc, w_Line_Next;
  logic             w_Blank_Exp, w_Violation;
  logic [2:0]       w_Class_Code;
  logic             w_Valid_Next, w_Frame_Start_Next, w_Locked_Next;
  logic [2:0]       w_Code_Next;
  logic [ERR_W-1:0] w_Err_Count_Next;

  vga_color_classify u_classify (
    .i_Red   (i_Red),
    .i_Green (i_Green),
    .i_Blue  (i_Blue),
    .o_Code  (w_Class_Code)
  );

  // Prediction is the coordinate this sample should have if timing is intact.
  assign w_HS_Fall   = r_HSync_Prev & ~i_hSync;
  assign w_VS_Fall   = r_VSync_Prev & ~i_vSync;
  assign w_X_Wrap    = (r_X == C_H_LAST);
  assign w_Pred_X    = w_X_Wrap ? '0 : r_X + 10'd1;
  assign w_Pred_Y    = !w_X_Wrap ? r_Y : ((r_Y == C_V_LAST) ? '0 : r_Y + 10'd1);
  assign w_X_New     = w_HS_Fall ? C_HS_START : w_Pred_X;
  assign w_Y_New     = w_VS_Fall ? C_VS_START : w_Pred_Y;
  assign w_Blank_Exp = (w_Pred_X < C_H_DISP) && (w_Pred_Y < C_V_DISP);
  assign w_Line_Inc  = (w_X_Wrap && (r_Line_Cnt != '1)) ? r_Line_Cnt + 10'd1 : r_Line_Cnt;

  assign w_Violation = (r_State == LOCKED) &&
                       ((w_HS_Fall && (w_Pred_X != C_HS_START)) ||
                        (w_VS_Fall && ((w_Pred_Y != C_VS_START) || (w_Pred_X != '0))) ||
                        (i_Blank != w_Blank_Exp));

  always_comb begin
    w_Next_State = r_State;
    case (r_State)
      SEARCH: if (w_VS_Fall) w_Next_State = TRACK;
      TRACK: begin
        if (w_HS_Fall && (w_Pred_X != C_HS_START))
          w_Next_State = SEARCH;
        else if (w_VS_Fall)
          w_Next_State = (w_Line_Inc == C_V_TOTAL) ? LOCKED : TRACK;
      end
      LOCKED: if (w_Violation) w_Next_State = SEARCH;
      default: w_Next_State = SEARCH;
    endcase
  end

  always_comb begin
    w_Line_Next = r_Line_Cnt;
    if ((r_State != LOCKED) && w_VS_Fall)
      w_Line_Next = '0;
    else if (r_State == TRACK)
      w_Line_Next = w_Line_Inc;

    w_Valid_Next       = (r_State == LOCKED) && !w_Violation &&
                         (w_X_New < C_H_DISP) && (w_Y_New < C_V_DISP);
    w_Code_Next        = w_Valid_Next ? w_Class_Code : CODE_BG;
    w_Frame_Start_Next = (r_State == LOCKED) && !w_Violation &&
                         (w_X_New == '0) && (w_Y_New == '0);
    w_Locked_Next      = (w_Next_State == LOCKED);
    w_Err_Count_Next   = r_Err_Count;
    if (w_Violation && (r_Err_Count != '1))
      w_Err_Count_Next = r_Err_Count + ERR_W'(1);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State       <= SEARCH;
      r_X           <= '0;
      r_Y           <= '0;
      r_Line_Cnt    <= '0;
      r_HSync_Prev  <= 1'b1;
      r_VSync_Prev  <= 1'b1;
      r_Locked      <= 1'b0;
      r_Error       <= 1'b0;
      r_Frame_Start <= 1'b0;
      r_Valid       <= 1'b0;
      r_Code        <= '0;
      r_Err_Count   <= '0;
    end else if (i_Pix_En) begin
      r_State       <= w_Next_State;
      r_X           <= w_X_New;
      r_Y           <= w_Y_New;
      r_Line_Cnt    <= w_Line_Next;
      r_HSync_Prev  <= i_hSync;
      r_VSync_Prev  <= i_vSync;
      r_Locked      <= w_Locked_Next;
      r_Error       <= w_Violation;
      r_Frame_Start <= w_Frame_Start_Next;
      r_Valid       <= w_Valid_Next;
      r_Code        <= w_Code_Next;
      r_Err_Count   <= w_Err_Count_Next;
    end else begin
      r_Error       <= 1'b0;
      r_Frame_Start <= 1'b0;
    end
  end

  assign o_Pixel_X     = r_X;
  assign o_Pixel_Y     = r_Y;
  assign o_Pixel_Valid = r_Valid;
  assign o_Pixel_Code  = r_Code;
  assign o_Frame_Start = r_Frame_Start;
  assign o_Locked      = r_Locked;
  assign o_Error       = r_Error;
  assign o_Err_Count   = r_Err_Count;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a shrunken 9x7 timing so that many
// frames (including 300 injected violations) fit in a short run.
module tb_vga_sync_decoder;

  localparam int HD = 6, HF = 1, HS = 1, HB = 1;
  localparam int VD = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int HSS = HD + HF;
  localparam int VSS = VD + VF;

  logic       i_Clk = 1'b0;
  logic       i_Reset, i_Pix_En, i_hSync, i_vSync, i_Blank;
  logic [7:0] i_Red, i_Green, i_Blue;
  logic [9:0] o_Pixel_X, o_Pixel_Y;
  logic       o_Pixel_Valid, o_Frame_Start, o_Locked, o_Error;
  logic [2:0] o_Pixel_Code;
  logic [7:0] o_Err_Count;

  int checks = 0, errors = 0;
  int g_x, g_y, g_vtot;
  bit cad;
  int err_pulses, fs_pulses;

  vga_sync_decoder #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .ERR_W(8)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Pix_En(i_Pix_En),
    .i_hSync(i_hSync), .i_vSync(i_vSync), .i_Blank(i_Blank),
    .i_Red(i_Red), .i_Green(i_Green), .i_Blue(i_Blue),
    .o_Pixel_X(o_Pixel_X), .o_Pixel_Y(o_Pixel_Y), .o_Pixel_Valid(o_Pixel_Valid),
    .o_Pixel_Code(o_Pixel_Code), .o_Frame_Start(o_Frame_Start),
    .o_Locked(o_Locked), .o_Error(o_Error), .o_Err_Count(o_Err_Count)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic gen_drive();
    i_hSync = !(g_x >= HSS && g_x < HSS + HS);
    i_vSync = !(g_y >= VSS && g_y < VSS + VS);
    i_Blank = (g_x < HD) && (g_y < VD);
    i_Red   = 8'd0;
    i_Green = 8'd0;
    i_Blue  = i_Blank ? 8'd255 : 8'd0;
  endtask

  task automatic tick();
    i_Pix_En = 1'b1;
    @(posedge i_Clk);
    #1;
    i_Pix_En = 1'b0;
    if (o_Error === 1'b1) err_pulses++;
    if (o_Frame_Start === 1'b1) fs_pulses++;
    if (cad) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  task automatic advance();
    if (g_x == HT - 1) begin
      g_x = 0;
      g_y = (g_y >= g_vtot - 1) ? 0 : g_y + 1;
    end else begin
      g_x++;
    end
  endtask

  task automatic pixel();
    gen_drive();
    tick();
    advance();
  endtask

  task automatic send_rgb(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    gen_drive();
    i_Red = rr; i_Green = gg; i_Blue = bb;
    tick();
    advance();
  endtask

  task automatic run_to(input int x, input int y);
    int n = 0;
    while (!(g_x == x && g_y == y) && n < 2000) begin
      pixel();
      n++;
    end
    chk("run_to_bound", 32'(n < 2000), 32'd1);
  endtask

  // From SEARCH: first vSync fall enters TRACK, lock exactly one frame later.
  task automatic relock();
    run_to(0, VSS);
    pixel();
    chk("relock_track", 32'(o_Locked), 32'd0);
    run_to(0, VSS);
    chk("relock_prelock", 32'(o_Locked), 32'd0);
    pixel();
    chk("relock_locked", 32'(o_Locked), 32'd1);
  endtask

  initial begin
    i_Reset = 1'b1; i_Pix_En = 1'b0;
    g_x = 0; g_y = 0; g_vtot = VT; cad = 1'b1;
    err_pulses = 0; fs_pulses = 0;
    gen_drive();
    repeat (3) @(posedge i_Clk);
    #1;
    chk("rst_locked", 32'(o_Locked), 32'd0);
    chk("rst_x", 32'(o_Pixel_X), 32'd0);
    chk("rst_y", 32'(o_Pixel_Y), 32'd0);
    chk("rst_valid", 32'(o_Pixel_Valid), 32'd0);
    chk("rst_code", 32'(o_Pixel_Code), 32'd0);
    chk("rst_err", 32'(o_Error), 32'd0);
    chk("rst_fs", 32'(o_Frame_Start), 32'd0);
    chk("rst_errcnt", 32'(o_Err_Count), 32'd0);
    i_Reset = 1'b0;

    // Initial lock with enable every second cycle
    run_to(0, VSS);
    pixel();
    chk("lock_first_vs", 32'(o_Locked), 32'd0);
    run_to(0, VSS);
    chk("lock_before_second_vs", 32'(o_Locked), 32'd0);
    pixel();
    chk("lock_second_vs", 32'(o_Locked), 32'd1);
    chk("lock_x", 32'(o_Pixel_X), 32'd0);
    chk("lock_y", 32'(o_Pixel_Y), 32'(VSS));

    err_pulses = 0; fs_pulses = 0;
    repeat (3 * HT * VT) pixel();
    chk("nominal_no_err", 32'(err_pulses), 32'd0);
    chk("nominal_fs_3", 32'(fs_pulses), 32'd3);
    chk("nominal_locked", 32'(o_Locked), 32'd1);

    cad = 1'b0;

    // Colour decode
    run_to(2, 1);
    send_rgb(8'd0, 8'd255, 8'd0);
    chk("col_x", 32'(o_Pixel_X), 32'd2);
    chk("col_y", 32'(o_Pixel_Y), 32'd1);
    chk("col_valid", 32'(o_Pixel_Valid), 32'd1);
    chk("col_green", 32'(o_Pixel_Code), 32'b010);
    send_rgb(8'd255, 8'd255, 8'd0);
    chk("col_yellow", 32'(o_Pixel_Code), 32'b011);
    send_rgb(8'd128, 8'd128, 8'd128);
    chk("col_unknown", 32'(o_Pixel_Code), 32'b111);
    send_rgb(8'd127, 8'd127, 8'd127);
    chk("col_127_valid", 32'(o_Pixel_Valid), 32'd1);
    chk("col_127_bg", 32'(o_Pixel_Code), 32'b000);
    send_rgb(8'd255, 8'd0, 8'd0);
    chk("blank_x", 32'(o_Pixel_X), 32'd6);
    chk("blank_valid", 32'(o_Pixel_Valid), 32'd0);
    chk("blank_code", 32'(o_Pixel_Code), 32'd0);
    run_to(0, 2);
    send_rgb(8'd255, 8'd0, 8'd0);
    chk("col_red", 32'(o_Pixel_Code), 32'b100);
    send_rgb(8'd0, 8'd0, 8'd128);
    chk("col_blue", 32'(o_Pixel_Code), 32'b001);
    chk("col_no_err", 32'(err_pulses), 32'd0);

    // hSync fall one pixel late on line 2
    err_pulses = 0;
    run_to(HSS, 2);
    gen_drive(); i_hSync = 1'b1; tick(); advance();
    chk("hdly_pre_noerr", 32'(err_pulses), 32'd0);
    gen_drive(); i_hSync = 1'b0; tick(); advance();
    chk("hdly_err", 32'(o_Error), 32'd1);
    chk("hdly_errcnt", 32'(o_Err_Count), 32'd1);
    chk("hdly_unlocked", 32'(o_Locked), 32'd0);
    relock();
    chk("hdly_single_pulse", 32'(err_pulses), 32'd1);

    // Blank forced low inside the active region
    err_pulses = 0;
    run_to(3, 3);
    gen_drive(); i_Blank = 1'b0; tick(); advance();
    chk("blank_err", 32'(o_Error), 32'd1);
    chk("blank_errcnt", 32'(o_Err_Count), 32'd2);
    chk("blank_unlocked", 32'(o_Locked), 32'd0);
    relock();
    chk("blank_single_pulse", 32'(err_pulses), 32'd1);

    // 298 more violations (300 total): counter saturates at 255
    err_pulses = 0;
    repeat (298) begin
      gen_drive(); i_Blank = 1'b1; tick(); advance();
      relock();
    end
    chk("sat_pulses", 32'(err_pulses), 32'd298);
    chk("sat_errcnt", 32'(o_Err_Count), 32'd255);

    // One TRACK frame a line short: no lock, no error; next good frame locks
    err_pulses = 0;
    gen_drive(); i_Blank = 1'b1; tick(); advance();
    chk("sat_hold_errcnt", 32'(o_Err_Count), 32'd255);
    run_to(0, VSS);
    pixel();
    g_vtot = VT - 1;
    run_to(0, 0);
    g_vtot = VT;
    run_to(0, VSS);
    pixel();
    chk("short_no_lock", 32'(o_Locked), 32'd0);
    chk("short_no_err", 32'(err_pulses), 32'd1);
    run_to(0, VSS);
    pixel();
    chk("short_then_lock", 32'(o_Locked), 32'd1);

    // Enable held low for 50 cycles right after the frame-start pixel
    run_to(0, 0);
    pixel();
    chk("hold_fs_pulse", 32'(o_Frame_Start), 32'd1);
    repeat (50) begin
      i_hSync = ~i_hSync; i_vSync = ~i_vSync; i_Blank = ~i_Blank;
      i_Red = 8'($urandom);
      @(posedge i_Clk);
      #1;
    end
    chk("hold_fs_clear", 32'(o_Frame_Start), 32'd0);
    chk("hold_x", 32'(o_Pixel_X), 32'd0);
    chk("hold_y", 32'(o_Pixel_Y), 32'd0);
    chk("hold_valid", 32'(o_Pixel_Valid), 32'd1);
    chk("hold_locked", 32'(o_Locked), 32'd1);

    // Reset mid-frame while locked
    run_to(3, 2);
    pixel();
    chk("prerst_valid", 32'(o_Pixel_Valid), 32'd1);
    i_Reset = 1'b1;
    @(posedge i_Clk);
    #1;
    i_Reset = 1'b0;
    chk("mrst_locked", 32'(o_Locked), 32'd0);
    chk("mrst_x", 32'(o_Pixel_X), 32'd0);
    chk("mrst_y", 32'(o_Pixel_Y), 32'd0);
    chk("mrst_valid", 32'(o_Pixel_Valid), 32'd0);
    chk("mrst_code", 32'(o_Pixel_Code), 32'd0);
    chk("mrst_errcnt", 32'(o_Err_Count), 32'd0);
    relock();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
